// File: rtl/cachesink.sv
// -----------------------------------------------------------------------------
// cachesink
// Request sink that models a simple cache. Every MISS_PERIOD-th accepted
// request is a miss and triggers a memory fill of FILL_BEATS acknowledged
// beats. All other accepted requests are hits and cost one busy cycle.
//
// Parameters:
//   MISS_PERIOD  1..15  every MISS_PERIOD-th acceptance is a miss
//   FILL_BEATS   1..15  mem_ack beats that complete one miss fill
//
// Ports:
//   clk         in   single clock, all state changes on the rising edge
//   rst         in   synchronous, active-high reset
//   valid_in    in   request strobe from the upstream generator
//   ready_out   out  high exactly while the FSM is IDLE
//   mem_stb     out  high exactly while the FSM is in FILL
//   mem_ack     in   one fill beat delivered by memory
//   req_count   out  saturating count of accepted requests
//   miss_count  out  saturating count of accepted misses
//   err_out     out  sticky flag: mem_ack seen outside FILL
// -----------------------------------------------------------------------------
module cachesink #(
   parameter int MISS_PERIOD = 4,
   parameter int FILL_BEATS  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   output logic        ready_out,
   output logic        mem_stb,
   input  logic        mem_ack,
   output logic [15:0] req_count,
   output logic [15:0] miss_count,
   output logic        err_out
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIT  = 2'd1,
      FILL = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [3:0] PHASE_LAST = 4'(MISS_PERIOD - 1);
   localparam logic [3:0] BEAT_LAST  = 4'(FILL_BEATS - 1);

   state_t      state_r;
   logic [3:0]  phase_r;
   logic [3:0]  beat_r;
   logic [15:0] req_count_r;
   logic [15:0] miss_count_r;
   logic        err_r;
   logic        ready_r;
   logic        stb_r;

   // Saturating 16-bit increment shared by both event counters.
   function automatic logic [15:0] sat_inc(input logic [15:0] value);
      if (value == 16'hFFFF) begin
         return value;
      end else begin
         return value + 16'd1;
      end
   endfunction

   // FSM, phase/beat counters, event counters and sticky error flag.
   // ready_r and mem_stb are registered alongside the state so that they
   // always equal (state == IDLE) and (state == FILL) respectively.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         phase_r      <= 4'd0;
         beat_r       <= 4'd0;
         req_count_r  <= 16'd0;
         miss_count_r <= 16'd0;
         err_r        <= 1'b0;
         ready_r      <= 1'b1;
         stb_r        <= 1'b0;
      end else begin
         // A stray beat is a protocol error; it never touches beat or state.
         if (mem_ack && (state_r != FILL)) begin
            err_r <= 1'b1;
         end else begin
            err_r <= err_r;
         end

         case (state_r)
            IDLE: begin
               if (valid_in) begin
                  req_count_r <= sat_inc(req_count_r);
                  ready_r     <= 1'b0;
                  if (phase_r == PHASE_LAST) begin
                     phase_r      <= 4'd0;
                     miss_count_r <= sat_inc(miss_count_r);
                     stb_r        <= 1'b1;
                     state_r      <= FILL;
                  end else begin
                     phase_r <= phase_r + 4'd1;
                     state_r <= HIT;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            HIT: begin
               ready_r <= 1'b1;
               state_r <= IDLE;
            end
            FILL: begin
               if (mem_ack) begin
                  if (beat_r == BEAT_LAST) begin
                     beat_r  <= 4'd0;
                     stb_r   <= 1'b0;
                     state_r <= DONE;
                  end else begin
                     beat_r <= beat_r + 4'd1;
                  end
               end else begin
                  beat_r <= beat_r;
               end
            end
            DONE: begin
               ready_r <= 1'b1;
               state_r <= IDLE;
            end
            default: begin
               ready_r <= 1'b1;
               stb_r   <= 1'b0;
               beat_r  <= 4'd0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign ready_out  = ready_r;
   assign mem_stb    = stb_r;
   assign req_count  = req_count_r;
   assign miss_count = miss_count_r;
   assign err_out    = err_r;

endmodule

// File: tb/tb_cachesink.sv
// -----------------------------------------------------------------------------
// tb_cachesink
// Directed bench for cachesink. u0 uses the default parameters, u1 uses
// MISS_PERIOD=1 / FILL_BEATS=1 for the back-to-back miss throughput case.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_cachesink;

   logic        clk;
   logic        rst;
   logic        v0, a0, v1, a1;
   logic        rdy0, stb0, err0, rdy1, stb1, err1;
   logic [15:0] req0, miss0, req1, miss1;
   int          n_assert;
   int          n_fail;

   cachesink #(.MISS_PERIOD(4), .FILL_BEATS(4)) u0 (
      .clk(clk), .rst(rst), .valid_in(v0), .ready_out(rdy0), .mem_stb(stb0),
      .mem_ack(a0), .req_count(req0), .miss_count(miss0), .err_out(err0)
   );

   cachesink #(.MISS_PERIOD(1), .FILL_BEATS(1)) u1 (
      .clk(clk), .rst(rst), .valid_in(v1), .ready_out(rdy1), .mem_stb(stb1),
      .mem_ack(a1), .req_count(req1), .miss_count(miss1), .err_out(err1)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One hit request on u0: one accept cycle, one busy cycle, then ready again.
   task automatic hit0(input logic [15:0] exp_req);
      v0 = 1'b1;
      tick();
      v0 = 1'b0;
      chk("hit_ready_low", 32'(rdy0), 32'd0);
      chk("hit_req_count", 32'(req0), 32'(exp_req));
      tick();
      chk("hit_ready_back", 32'(rdy0), 32'd1);
   endtask

   // Linear sequence of directed steps.
   initial begin
      logic [6:0] pat;
      n_assert = 0;
      n_fail   = 0;
      rst = 1'b1; v0 = 1'b0; a0 = 1'b0; v1 = 1'b0; a1 = 1'b0;
      #1;
      tick();
      tick();
      chk("rst_ready", 32'(rdy0), 32'd1);
      chk("rst_stb", 32'(stb0), 32'd0);
      chk("rst_req", 32'(req0), 32'd0);
      chk("rst_miss", 32'(miss0), 32'd0);
      chk("rst_err", 32'(err0), 32'd0);
      rst = 1'b0;

      // Idle for 20 cycles: nothing moves.
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle_outputs", {rdy0, stb0, err0, req0, miss0}, {1'b1, 1'b0, 1'b0, 16'd0, 16'd0});
      end

      // Three hits with 6-cycle gaps.
      for (int k = 1; k <= 3; k++) begin
         hit0(16'(k));
         for (int g = 0; g < 5; g++) tick();
      end
      chk("hits_req", 32'(req0), 32'd3);
      chk("hits_miss", 32'(miss0), 32'd0);

      // Fourth request misses; ack on every FILL cycle.
      v0 = 1'b1;
      tick();
      v0 = 1'b0;
      chk("miss_req", 32'(req0), 32'd4);
      chk("miss_miss", 32'(miss0), 32'd1);
      a0 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("fill_stb_high", 32'(stb0), 32'd1);
         chk("fill_ready_low", 32'(rdy0), 32'd0);
         tick();
      end
      a0 = 1'b0;
      chk("done_stb_low", 32'(stb0), 32'd0);
      chk("done_ready_low", 32'(rdy0), 32'd0);
      tick();
      chk("after_done_ready", 32'(rdy0), 32'd1);
      chk("after_done_err", 32'(err0), 32'd0);

      // Sparse ack pattern 1,0,0,1,1,0,1 on the next miss.
      hit0(16'd5);
      hit0(16'd6);
      hit0(16'd7);
      v0 = 1'b1;
      tick();
      v0 = 1'b0;
      chk("miss2_req", 32'(req0), 32'd8);
      chk("miss2_miss", 32'(miss0), 32'd2);
      pat = 7'b1011001;   // bit i is the ack in FILL cycle i
      for (int i = 0; i < 7; i++) begin
         chk("sparse_stb_high", 32'(stb0), 32'd1);
         a0 = pat[i];
         tick();
      end
      a0 = 1'b0;
      chk("sparse_exit_stb", 32'(stb0), 32'd0);
      chk("sparse_exit_ready", 32'(rdy0), 32'd0);
      tick();
      chk("sparse_idle", 32'(rdy0), 32'd1);
      chk("sparse_err_clear", 32'(err0), 32'd0);
      a0 = 1'b1;
      tick();
      a0 = 1'b0;
      chk("stray_ack_err", 32'(err0), 32'd1);
      chk("stray_ack_ready", 32'(rdy0), 32'd1);
      chk("stray_ack_stb", 32'(stb0), 32'd0);
      tick();
      tick();
      chk("err_sticky", 32'(err0), 32'd1);

      // Reset in the middle of a fill after 2 of 4 acks.
      hit0(16'd9);
      hit0(16'd10);
      hit0(16'd11);
      v0 = 1'b1;
      tick();
      v0 = 1'b0;
      a0 = 1'b1;
      tick();
      tick();
      a0 = 1'b0;
      chk("midfill_stb", 32'(stb0), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_ready", 32'(rdy0), 32'd1);
      chk("midrst_stb", 32'(stb0), 32'd0);
      chk("midrst_req", 32'(req0), 32'd0);
      chk("midrst_miss", 32'(miss0), 32'd0);
      chk("midrst_err", 32'(err0), 32'd0);
      a0 = 1'b1;
      tick();
      a0 = 1'b0;
      chk("post_rst_ack_err", 32'(err0), 32'd1);
      hit0(16'd1);
      hit0(16'd2);
      hit0(16'd3);
      chk("post_rst_no_miss", 32'(miss0), 32'd0);
      v0 = 1'b1;
      tick();
      v0 = 1'b0;
      chk("post_rst_4th_stb", 32'(stb0), 32'd1);
      chk("post_rst_4th_miss", 32'(miss0), 32'd1);
      chk("post_rst_4th_req", 32'(req0), 32'd4);

      // u1: every request misses with a single-beat fill -> 3-cycle period.
      v1 = 1'b1;
      a1 = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         tick();
         chk("p1_ready_period", 32'(rdy1), ((i % 3) == 0) ? 32'd1 : 32'd0);
      end
      v1 = 1'b0;
      a1 = 1'b0;
      chk("p1_req", 32'(req1), 32'd100);
      chk("p1_miss", 32'(miss1), 32'd100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
